// File: rtl/snn_layer_sched_if.sv
// Handshake bundle between the SNN layer scheduler and its datapath/memory side.
interface snn_layer_sched_if;
  logic       start;
  logic       memReady;
  logic       layer_done;
  logic       busy;
  logic       data_load;
  logic [1:0] layer_addr;
  logic [2:0] timestep;
  logic       run_start;
  logic       spike_buffer_toggle;
  logic       done;
  logic       err;

  // Requester side: starts inferences, reports cache and datapath status.
  modport master (
    output start, memReady, layer_done,
    input  busy, data_load, layer_addr, timestep, run_start,
           spike_buffer_toggle, done, err
  );

  // Scheduler side.
  modport slave (
    input  start, memReady, layer_done,
    output busy, data_load, layer_addr, timestep, run_start,
           spike_buffer_toggle, done, err
  );
endinterface

// File: rtl/snn_layer_sched.sv
// Sequences one SNN inference: for each layer, load its weights, then run
// every timestep on the datapath, flipping the ping-pong spike buffer after
// each completed timestep.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | waiting for start
// LOAD_REQ  | data_load pulse for layer_addr
// LOAD_WAIT | waiting for memReady, bounded by TIMEOUT cycles
// RUN_REQ   | run_start pulse for (layer_addr, timestep)
// RUN_WAIT  | waiting for layer_done, unbounded
// SWAP      | flip spike buffer, advance timestep / layer
// FIN       | done pulse, then back to IDLE
module snn_layer_sched #(
  parameter int NUM_LAYERS    = 3,
  parameter int NUM_TIMESTEPS = 8,
  parameter int TIMEOUT       = 16
) (
  input  logic              clk,
  input  logic              reset,
  snn_layer_sched_if.slave  bus
);

  localparam int             WCW        = $clog2(TIMEOUT + 1);
  localparam logic [1:0]     LAST_LAYER = 2'(NUM_LAYERS - 1);
  localparam logic [2:0]     LAST_TS    = 3'(NUM_TIMESTEPS - 1);
  localparam logic [WCW-1:0] WAIT_LAST  = WCW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_REQ, LOAD_WAIT, RUN_REQ, RUN_WAIT, SWAP, FIN
  } state_t;

  state_t         state;
  logic [WCW-1:0] wait_cnt;
  logic [1:0]     layer_q;
  logic [2:0]     ts_q;
  logic           busy_q;
  logic           data_load_q;
  logic           run_start_q;
  logic           toggle_q;
  logic           done_q;
  logic           err_q;

  // Outputs are set on the transition into the state that owns them, so
  // every pulse lines up with its state and all outputs come from flops.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      layer_q     <= '0;
      ts_q        <= '0;
      busy_q      <= 1'b0;
      data_load_q <= 1'b0;
      run_start_q <= 1'b0;
      toggle_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      data_load_q <= 1'b0;
      run_start_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state       <= LOAD_REQ;
            busy_q      <= 1'b1;
            data_load_q <= 1'b1;
            layer_q     <= '0;
            ts_q        <= '0;
            wait_cnt    <= '0;
          end
        end
        LOAD_REQ: state <= LOAD_WAIT;
        LOAD_WAIT: begin
          // memReady wins on the last allowed cycle; indices hold on timeout.
          if (bus.memReady) begin
            state       <= RUN_REQ;
            run_start_q <= 1'b1;
          end else if (wait_cnt == WAIT_LAST) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            err_q  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RUN_REQ: state <= RUN_WAIT;
        RUN_WAIT: begin
          if (bus.layer_done) state <= SWAP;
        end
        SWAP: begin
          toggle_q <= ~toggle_q;
          if (ts_q != LAST_TS) begin
            ts_q        <= ts_q + 1'b1;
            state       <= RUN_REQ;
            run_start_q <= 1'b1;
          end else if (layer_q != LAST_LAYER) begin
            ts_q        <= '0;
            layer_q     <= layer_q + 1'b1;
            wait_cnt    <= '0;
            state       <= LOAD_REQ;
            data_load_q <= 1'b1;
          end else begin
            state  <= FIN;
            done_q <= 1'b1;
          end
        end
        FIN: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy                = busy_q;
  assign bus.data_load           = data_load_q;
  assign bus.layer_addr          = layer_q;
  assign bus.timestep            = ts_q;
  assign bus.run_start           = run_start_q;
  assign bus.spike_buffer_toggle = toggle_q;
  assign bus.done                = done_q;
  assign bus.err                 = err_q;

endmodule

// File: doc/snn_layer_sched.md
SNN_LAYER_SCHED -- requirements
Module: snn_layer_sched

Interface
REQ-001 Parameter NUM_LAYERS, default 3, number of weight layers sequenced per inference.
REQ-002 Parameter NUM_TIMESTEPS, default 8, timesteps executed per layer.
REQ-003 Parameter TIMEOUT, default 16, maximum LOAD_WAIT cycles before memReady is declared missing.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset (reset==0 at a rising edge resets the block).
REQ-006 start  input  1  request to begin one inference; sampled only in IDLE.
REQ-007 memReady  input  1  level; weight cache for the current layer is loaded.
REQ-008 layer_done  input  1  one-cycle pulse; datapath finished the current layer for the current timestep.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 data_load  output  1  one-cycle pulse requesting a weight-cache load for layer_addr.
REQ-011 layer_addr  output  2  current layer index, 0..NUM_LAYERS-1.
REQ-012 timestep  output  3  current timestep index, 0..NUM_TIMESTEPS-1.
REQ-013 run_start  output  1  one-cycle pulse starting the datapath for (layer_addr, timestep).
REQ-014 spike_buffer_toggle  output  1  level; selects the ping-pong spike buffer and inverts once per completed timestep.
REQ-015 done  output  1  one-cycle pulse at inference completion.
REQ-016 err  output  1  one-cycle pulse on memReady timeout.

Function
REQ-017 FSM states SHALL be IDLE, LOAD_REQ, LOAD_WAIT, RUN_REQ, RUN_WAIT, SWAP, FIN; all outputs SHALL be registered.
REQ-018 IDLE: start==1 -> LOAD_REQ; layer_addr, timestep and wait counter SHALL clear to 0.
REQ-019 LOAD_REQ: data_load SHALL be 1 for exactly this cycle; next state SHALL be LOAD_WAIT.
REQ-020 LOAD_WAIT: memReady==1 -> RUN_REQ; otherwise the wait counter SHALL increment by 1 per cycle.
REQ-021 LOAD_WAIT with the wait counter reaching TIMEOUT-1 and memReady==0 -> IDLE, with err high for 1 cycle; layer_addr and timestep SHALL hold their values.
REQ-022 memReady SHALL be sampled only in LOAD_WAIT, so a level already high on entry is accepted on the first LOAD_WAIT cycle.
REQ-023 RUN_REQ: run_start SHALL be 1 for exactly this cycle; next state SHALL be RUN_WAIT.
REQ-024 RUN_WAIT: layer_done==1 -> SWAP; there SHALL be no timeout in RUN_WAIT.
REQ-025 SWAP SHALL invert spike_buffer_toggle.
REQ-026 SWAP with timestep<NUM_TIMESTEPS-1 SHALL increment timestep and go to RUN_REQ.
REQ-027 SWAP with timestep==NUM_TIMESTEPS-1 and layer_addr<NUM_LAYERS-1 SHALL set timestep to 0, increment layer_addr, clear the wait counter and go to LOAD_REQ.
REQ-028 SWAP with timestep==NUM_TIMESTEPS-1 and layer_addr==NUM_LAYERS-1 SHALL go to FIN.
REQ-029 FIN: done SHALL be 1 for exactly this cycle; next state SHALL be IDLE; layer_addr and timestep SHALL hold their final values.
REQ-030 start outside IDLE, layer_done outside RUN_WAIT and memReady outside LOAD_WAIT SHALL be ignored.
REQ-031 Minimum per-timestep latency: run_start to the next run_start is 3 cycles when layer_done arrives in the first RUN_WAIT cycle.
REQ-032 spike_buffer_toggle SHALL NOT change in IDLE, so its value carries across inferences and is cleared only by reset.

Reset
REQ-033 When reset==0 at a rising edge: state SHALL be IDLE; busy, data_load, run_start, done, err and spike_buffer_toggle SHALL be 0; layer_addr, timestep and the wait counter SHALL be 0.
REQ-034 Reset SHALL take priority over every input in every state, including mid-LOAD_WAIT and mid-RUN_WAIT; no pulse output SHALL be issued in the reset cycle.

Verification
REQ-035 Full run (defaults, memReady tied 1, layer_done 1 cycle after each run_start) -> 3 data_load pulses, 24 run_start pulses, 24 toggle inversions (final value 0), 1 done pulse, busy low afterwards.
REQ-036 memReady held 0 after start -> err pulse exactly 16 cycles after entering LOAD_WAIT, state IDLE, busy 0, no run_start.
REQ-037 start pulsed again while in RUN_WAIT -> no effect: data_load count and layer_addr unchanged.
REQ-038 reset driven 0 during RUN_WAIT at layer_addr=1, timestep=5 -> next cycle all outputs 0, state IDLE; a subsequent start restarts at layer 0, timestep 0.
REQ-039 layer_done pulsed in IDLE and in LOAD_WAIT -> ignored: no SWAP, timestep and toggle unchanged.
REQ-040 memReady already high on entry to LOAD_WAIT -> run_start occurs exactly 2 cycles after the data_load pulse.
